controlador_entrada_saida: RTL and testbench

CONTROLADOR_ENTRADA_SAIDA -- requirements
Module: controlador_entrada_saida

---
 rtl/controlador_entrada_saida.sv | 150 +++++++++++++++
 tb/tb_controlador_entrada_saida.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_entrada_saida.sv
// Handshake between the control unit and the board I/O: debounced switch capture
// for input instructions and an edge-triggered display latch for output instructions.
module controlador_entrada_saida #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int LARGURA_SWITCH  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      estagioEntradaUC,
  input  logic                      estagioSaidaUC,
  input  logic                      botaoConfirma,
  input  logic [LARGURA_SWITCH-1:0] switches,
  input  logic [31:0]               dadoSaida,
  output logic                      estagioEntradaSwitch,
  output logic                      estagioEntradaBanco,
  output logic [31:0]               dadoSwitch,
  output logic [31:0]               displayDado,
  output logic                      displayValido
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARMA         = 3'd1,
    ESPERA_PRESS = 3'd2,
    ESPERA_SOLTA = 3'd3,
    ESCRITA      = 3'd4,
    CONCLUI      = 3'd5
  } estado_t;

  localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS);

  estado_t     r_estado, w_prox_estado;
  logic [7:0]  r_cont, w_prox_cont, w_cont_inc;
  logic        r_sinc1, r_sinc2;
  logic        r_entrada_ok, r_saida_ant, r_valido;
  logic [31:0] r_dado_sw, r_display;
  logic        w_botao, w_estavel, w_captura, w_limpa_ok, w_banco;

  assign w_botao    = r_sinc2;
  assign w_cont_inc = (r_cont == 8'hFF) ? r_cont : r_cont + 8'd1;
  assign w_estavel  = (w_cont_inc >= LIMITE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sinc1 <= 1'b0;
      r_sinc2 <= 1'b0;
    end else begin
      r_sinc1 <= botaoConfirma;
      r_sinc2 <= r_sinc1;
    end
  end

  // Counter restarts on every state change so each phase needs its own stable run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= IDLE;
      r_cont   <= 8'd0;
    end else begin
      r_estado <= w_prox_estado;
      r_cont   <= (w_prox_estado != r_estado) ? 8'd0 : w_prox_cont;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_cont   = 8'd0;
    w_captura     = 1'b0;
    w_limpa_ok    = 1'b0;
    w_banco       = 1'b0;
    case (r_estado)
      IDLE: begin
        if (estagioEntradaUC) w_prox_estado = ARMA;
      end
      ARMA: begin
        if (!estagioEntradaUC) begin
          w_prox_estado = IDLE;
          w_limpa_ok    = 1'b1;
        end else if (!w_botao) begin
          w_prox_cont = w_cont_inc;
          if (w_estavel) w_prox_estado = ESPERA_PRESS;
        end
      end
      ESPERA_PRESS: begin
        if (!estagioEntradaUC) begin
          w_prox_estado = IDLE;
          w_limpa_ok    = 1'b1;
        end else if (w_botao) begin
          w_prox_cont = w_cont_inc;
          if (w_estavel) begin
            w_captura     = 1'b1;
            w_prox_estado = ESPERA_SOLTA;
          end
        end
      end
      ESPERA_SOLTA: begin
        if (!estagioEntradaUC) begin
          w_prox_estado = IDLE;
          w_limpa_ok    = 1'b1;
        end else if (!w_botao) begin
          w_prox_cont = w_cont_inc;
          if (w_estavel) w_prox_estado = ESCRITA;
        end
      end
      ESCRITA: begin
        w_banco       = 1'b1;
        w_prox_estado = CONCLUI;
      end
      CONCLUI: begin
        if (!estagioEntradaUC) begin
          w_prox_estado = IDLE;
          w_limpa_ok    = 1'b1;
        end
      end
      default: w_prox_estado = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_entrada_ok <= 1'b0;
      r_dado_sw    <= 32'd0;
    end else if (w_captura) begin
      r_entrada_ok <= 1'b1;
      r_dado_sw    <= 32'(switches);
    end else if (w_limpa_ok) begin
      r_entrada_ok <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_saida_ant <= 1'b0;
      r_display   <= 32'd0;
      r_valido    <= 1'b0;
    end else begin
      r_saida_ant <= estagioSaidaUC;
      if (estagioSaidaUC && !r_saida_ant) begin
        r_display <= dadoSaida;
        r_valido  <= 1'b1;
      end
    end
  end

  assign estagioEntradaSwitch = r_entrada_ok;
  assign estagioEntradaBanco  = w_banco;
  assign dadoSwitch           = r_dado_sw;
  assign displayDado          = r_display;
  assign displayValido        = r_valido;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// phase/sample-history model of the I/O controller.
module tb_controlador_entrada_saida;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        entUC = 1'b0;
  logic        saidaUC = 1'b0;
  logic        botao = 1'b0;
  logic [15:0] sw = 16'd0;
  logic [31:0] dSaida = 32'd0;
  logic        o_ok, o_banco, o_valido;
  logic [31:0] o_dado, o_disp;

  controlador_entrada_saida #(.DEBOUNCE_CICLOS(DEB), .LARGURA_SWITCH(16)) dut (
    .clock(clock),
    .reset(reset),
    .estagioEntradaUC(entUC),
    .estagioSaidaUC(saidaUC),
    .botaoConfirma(botao),
    .switches(sw),
    .dadoSaida(dSaida),
    .estagioEntradaSwitch(o_ok),
    .estagioEntradaBanco(o_banco),
    .dadoSwitch(o_dado),
    .displayDado(o_disp),
    .displayValido(o_valido)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_banco = 0;
  int cyc_banco = -1;

  // Reference model: phase 0 idle, 1 waiting release-before-press, 2 waiting press,
  // 3 waiting release, 4 write strobe, 5 done.
  int          m_fase = 0;
  logic        m_h1 = 1'b0, m_h2 = 1'b0;
  logic        m_ok = 1'b0, m_val = 1'b0, m_prev = 1'b0;
  logic [31:0] m_dado = 32'd0, m_disp = 32'd0;
  int          amostras[$];

  function automatic bit estavel(int nivel);
    if (amostras.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (amostras[amostras.size() - 1 - i] != nivel) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelo();
    int sinc;
    int nivel;
    if (!reset) begin
      m_fase = 0; m_h1 = 0; m_h2 = 0; m_ok = 0; m_val = 0; m_prev = 0;
      m_dado = 0; m_disp = 0;
      amostras.delete();
      return;
    end
    sinc = int'(m_h2);
    m_h2 = m_h1;
    m_h1 = botao;
    if (saidaUC && !m_prev) begin
      m_disp = dSaida;
      m_val  = 1'b1;
    end
    m_prev = saidaUC;
    case (m_fase)
      0: if (entUC) begin m_fase = 1; amostras.delete(); end
      1, 2, 3: begin
        if (!entUC) begin
          m_fase = 0;
          m_ok   = 1'b0;
        end else begin
          nivel = (m_fase == 2) ? 1 : 0;
          amostras.push_back(sinc);
          if (amostras.size() > 64) void'(amostras.pop_front());
          if (estavel(nivel)) begin
            if (m_fase == 2) begin
              m_dado = {16'd0, sw};
              m_ok   = 1'b1;
            end
            m_fase = m_fase + 1;
            amostras.delete();
          end
        end
      end
      4: m_fase = 5;
      5: if (!entUC) begin m_fase = 0; m_ok = 1'b0; end
      default: m_fase = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelo();
    #1;
    cyc++;
    if (o_banco === 1'b1) begin
      n_banco++;
      cyc_banco = cyc;
    end
    chk("entrada_switch", {31'd0, o_ok}, {31'd0, m_ok});
    chk("entrada_banco", {31'd0, o_banco}, {31'd0, (m_fase == 4)});
    chk("dado_switch", o_dado, m_dado);
    chk("display_dado", o_disp, m_disp);
    chk("display_valido", {31'd0, o_valido}, {31'd0, m_val});
  endtask

  task automatic rep(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0;
    int b0;
    int hold;

    // Reset state
    rep(3);
    chk("rst_ok", {31'd0, o_ok}, 32'd0);
    chk("rst_dado", o_dado, 32'd0);
    chk("rst_valido", {31'd0, o_valido}, 32'd0);

    // Normal input sequence
    reset = 1; entUC = 1; botao = 0;
    rep(6);
    sw = 16'hA5A5; botao = 1;
    rep(6);
    chk("normal_capture_ok", {31'd0, o_ok}, 32'd1);
    chk("normal_capture_dado", o_dado, 32'h0000A5A5);
    b0 = n_banco; c0 = cyc; cyc_banco = -1;
    botao = 0; sw = 16'h0F0F;
    rep(10);
    chk("normal_banco_pulses", n_banco - b0, 32'd1);
    chk("normal_banco_latency", cyc_banco - c0, 32'd6);
    chk("normal_dado_hold", o_dado, 32'h0000A5A5);
    entUC = 0;
    tick();
    chk("normal_drop_ok", {31'd0, o_ok}, 32'd0);

    // Bouncing press, then a stable press
    entUC = 1; botao = 0; sw = 16'h1357;
    rep(6);
    for (int i = 0; i < 20; i++) begin
      botao = ((i / 2) % 2 == 0);
      tick();
    end
    chk("bounce_no_capture", {31'd0, o_ok}, 32'd0);
    botao = 1;
    rep(6);
    chk("bounce_capture", {31'd0, o_ok}, 32'd1);
    chk("bounce_dado", o_dado, 32'h00001357);
    botao = 0;
    rep(10);
    entUC = 0;
    tick();

    // Button already held when the instruction starts
    botao = 1;
    rep(4);
    entUC = 1; sw = 16'h2468;
    rep(12);
    chk("held_no_capture", {31'd0, o_ok}, 32'd0);
    chk("held_dado_old", o_dado, 32'h00001357);
    botao = 0;
    rep(6);
    botao = 1;
    rep(6);
    chk("held_capture", o_dado, 32'h00002468);
    botao = 0;
    rep(10);
    entUC = 0;
    tick();

    // Abort while waiting for release
    b0 = n_banco;
    entUC = 1; botao = 0; sw = 16'h1234;
    rep(6);
    botao = 1;
    rep(6);
    chk("abort_capture", {31'd0, o_ok}, 32'd1);
    botao = 0;
    rep(2);
    entUC = 0;
    tick();
    chk("abort_ok_clear", {31'd0, o_ok}, 32'd0);
    rep(8);
    chk("abort_no_banco", n_banco - b0, 32'd0);
    chk("abort_dado_kept", o_dado, 32'h00001234);

    // Output latch on rising edge only
    dSaida = 32'hDEADBEEF; saidaUC = 1;
    tick();
    dSaida = 32'd0;
    rep(2);
    saidaUC = 0;
    tick();
    chk("saida_display", o_disp, 32'hDEADBEEF);
    chk("saida_valido", {31'd0, o_valido}, 32'd1);

    // Reset in the middle of a press
    b0 = n_banco;
    entUC = 1; botao = 0;
    rep(6);
    botao = 1;
    rep(2);
    reset = 0;
    tick();
    chk("midrst_ok", {31'd0, o_ok}, 32'd0);
    chk("midrst_dado", o_dado, 32'd0);
    chk("midrst_disp", o_disp, 32'd0);
    chk("midrst_valido", {31'd0, o_valido}, 32'd0);
    reset = 1; entUC = 0; botao = 0;
    rep(8);
    chk("midrst_no_banco", n_banco - b0, 32'd0);

    // Random traffic
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        botao = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(1, 9));
      end
      hold--;
      if (entUC) begin
        if ($urandom_range(0, 59) == 0) entUC = 0;
      end else if ($urandom_range(0, 4) == 0) begin
        entUC = 1;
      end
      saidaUC = ($urandom_range(0, 3) == 0);
      dSaida  = $urandom;
      sw      = 16'($urandom);
      reset   = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
